vec4_stream_unpack: RTL and testbench

VEC4_STREAM_UNPACK -- requirements
Module: vec4_stream_unpack

---
 rtl/glut_pkg.sv | 30 +++
 rtl/glut_sync_fifo.sv | 68 ++++++
 rtl/vec4_stream_unpack.sv | 136 +++++++++++++
 tb/tb_vec4_stream_unpack.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/glut_pkg.sv
// ======================================================================
// glut_pkg : shared lane/vector geometry and unpacker state encoding
// Revision : 1.0
// ======================================================================
`default_nettype none

package glut_pkg;

   localparam int LANE_W     = 32;
   localparam int LANES      = 4;
   localparam int VEC_W      = 128;
   localparam int LANE_IDX_W = $clog2(LANES);

   localparam logic [LANE_IDX_W-1:0] LAST_LANE = LANE_IDX_W'(LANES - 1);

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_EMIT  = 1'b1
   } unpack_state_e;

   function automatic logic [LANE_W-1:0] lane_sel(
      input logic [VEC_W-1:0]      vec,
      input logic [LANE_IDX_W-1:0] idx
   );
      return vec[idx*LANE_W +: LANE_W];
   endfunction

endpackage

`default_nettype wire

// File: rtl/glut_sync_fifo.sv
// ======================================================================
// glut_sync_fifo : single-clock FIFO, fall-through read, registered level
// Revision : 1.0
// ======================================================================
`default_nettype none

module glut_sync_fifo #(
   parameter int WIDTH = 128,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [AW:0]      level_q, level_d;
   logic             do_wr, do_rd;

   // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign rdata = mem[rd_ptr_q[AW-1:0]];
   assign level = level_q;

   always_comb begin
      do_rd    = pop && !empty;
      do_wr    = push && (!full || do_rd);
      wr_ptr_d = do_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = do_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;
      case ({do_wr, do_rd})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

`default_nettype wire

// File: rtl/vec4_stream_unpack.sv
// ======================================================================
// vec4_stream_unpack : 128-bit beat FIFO unpacked to a framed 32-bit stream
// Revision : 1.0
// ======================================================================
`default_nettype none

module vec4_stream_unpack
   import glut_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int FRAME_W    = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          clear,
   input  logic [FRAME_W-1:0]            frame_len,
   input  logic                          s_tvalid,
   input  logic [VEC_W-1:0]              s_tdata,
   output logic                          m_tvalid,
   input  logic                          m_tready,
   output logic [LANE_W-1:0]             m_tdata,
   output logic                          m_tlast,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   function automatic logic [FRAME_W-1:0] last_beat(input logic [FRAME_W-1:0] f);
      return (f == '0) ? '0 : f - 1'b1;
   endfunction

   logic                   flush, hs;
   logic                   fifo_full, fifo_empty, fifo_pop;
   logic [VEC_W-1:0]       fifo_rdata;

   unpack_state_e          state_q, state_d;
   logic [VEC_W-1:0]       beat_q, beat_d;
   logic [LANE_IDX_W-1:0]  lane_q, lane_d;
   logic [FRAME_W-1:0]     cnt_q, cnt_d;
   logic [FRAME_W-1:0]     flen_q, flen_d;
   logic                   m_tvalid_q, m_tvalid_d;
   logic [LANE_W-1:0]      m_tdata_q, m_tdata_d;
   logic                   m_tlast_q, m_tlast_d;
   logic                   overflow_q, overflow_d;

   assign flush = rst | clear;
   assign hs    = m_tvalid_q & m_tready;

   glut_sync_fifo #(
      .WIDTH (VEC_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (flush),
      .push  (s_tvalid),
      .pop   (fifo_pop),
      .wdata (s_tdata),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_comb begin
      state_d  = state_q;
      beat_d   = beat_q;
      lane_d   = lane_q;
      cnt_d    = cnt_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (!fifo_empty) begin
               fifo_pop = 1'b1;
               beat_d   = fifo_rdata;
               lane_d   = '0;
               state_d  = ST_EMIT;
            end
         end
         ST_EMIT: begin
            if (hs) begin
               if (lane_q == LAST_LANE) begin
                  cnt_d  = (cnt_q == last_beat(flen_q)) ? '0 : cnt_q + 1'b1;
                  lane_d = '0;
                  // Refill straight from the FIFO so consecutive beats leave no bubble.
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     beat_d   = fifo_rdata;
                  end else begin
                     state_d = ST_EMPTY;
                  end
               end else begin
                  lane_d = lane_q + 1'b1;
               end
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      flen_d     = (cnt_d == '0 && lane_d == '0) ? frame_len : flen_q;
      m_tvalid_d = (state_d == ST_EMIT);
      m_tdata_d  = m_tvalid_d ? lane_sel(beat_d, lane_d) : '0;
      m_tlast_d  = m_tvalid_d && (lane_d == LAST_LANE) && (cnt_d == last_beat(flen_d));
      overflow_d = overflow_q | (s_tvalid & fifo_full & ~fifo_pop);
   end

   always_ff @(posedge clk) begin
      if (flush) begin
         state_q    <= ST_EMPTY;
         beat_q     <= '0;
         lane_q     <= '0;
         cnt_q      <= '0;
         flen_q     <= '0;
         m_tvalid_q <= 1'b0;
         m_tdata_q  <= '0;
         m_tlast_q  <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         lane_q     <= lane_d;
         cnt_q      <= cnt_d;
         flen_q     <= flen_d;
         m_tvalid_q <= m_tvalid_d;
         m_tdata_q  <= m_tdata_d;
         m_tlast_q  <= m_tlast_d;
         overflow_q <= overflow_d;
      end
   end

   assign m_tvalid = m_tvalid_q;
   assign m_tdata  = m_tdata_q;
   assign m_tlast  = m_tlast_q;
   assign overflow = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_vec4_stream_unpack.sv
// ======================================================================
// tb_vec4_stream_unpack : directed stimulus with queue-based output scoreboard
// Revision : 1.0
// ======================================================================
`default_nettype none

module tb_vec4_stream_unpack;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         clear = 1'b0;
   logic [7:0]   frame_len = 8'd1;
   logic         s_tvalid = 1'b0;
   logic [127:0] s_tdata = '0;
   logic         m_tready = 1'b0;
   logic         m_tvalid;
   logic [31:0]  m_tdata;
   logic         m_tlast;
   logic [3:0]   fifo_level;
   logic         overflow;

   int           total = 0;
   int           bad = 0;
   logic [32:0]  exp_q[$];
   int           words_seen = 0;
   int           cyc = 0;
   int           first_v = -1;
   int           last_v = -1;
   int           lvl_max = 0;
   int           base;
   int           n;

   vec4_stream_unpack #(
      .FIFO_DEPTH (8),
      .FRAME_W    (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .frame_len  (frame_len),
      .s_tvalid   (s_tvalid),
      .s_tdata    (s_tdata),
      .m_tvalid   (m_tvalid),
      .m_tready   (m_tready),
      .m_tdata    (m_tdata),
      .m_tlast    (m_tlast),
      .fifo_level (fifo_level),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [127:0] mk(input logic [31:0] b);
      return {b + 32'd3, b + 32'd2, b + 32'd1, b};
   endfunction

   // Output monitor: every accepted word is matched against the scoreboard head.
   always @(negedge clk) begin : monitor
      logic [32:0] e;
      cyc++;
      if (m_tvalid) begin
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
      end
      if (int'(fifo_level) > lvl_max) lvl_max = int'(fifo_level);
      if (m_tvalid && m_tready) begin
         words_seen++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_word: got %h last=%b with nothing expected", m_tdata, m_tlast);
         end else begin
            e = exp_q.pop_front();
            check("word", {31'd0, m_tlast, m_tdata}, {31'd0, e});
         end
      end
   end

   task automatic send(input logic [127:0] d, input bit last, input bit keep);
      @(posedge clk);
      #1;
      s_tvalid = 1'b1;
      s_tdata  = d;
      if (keep) begin
         for (int k = 0; k < 4; k++) begin
            exp_q.push_back({(last && k == 3), d[32*k +: 32]});
         end
      end
   endtask

   task automatic stop_send();
      @(posedge clk);
      #1;
      s_tvalid = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int c = 0;
      while ((exp_q.size() != 0 || m_tvalid) && c < budget) begin
         @(negedge clk);
         c++;
      end
      total++;
      if (exp_q.size() != 0 || m_tvalid) begin
         bad++;
         $display("FAIL %s: drain timeout with %0d words outstanding, required 0", name, exp_q.size());
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with a beat on the input that must be discarded.
      rst = 1'b1;
      s_tvalid = 1'b1;
      s_tdata = mk(32'hDEAD0000);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      s_tvalid = 1'b0;
      @(negedge clk);
      check("rst_valid", m_tvalid, 0);
      check("rst_last", m_tlast, 0);
      check("rst_data", m_tdata, 0);
      check("rst_level", fifo_level, 0);
      check("rst_overflow", overflow, 0);

      // Single beat latency and lane order.
      frame_len = 8'd1;
      m_tready  = 1'b1;
      send(128'h40400000_40000000_3F800000_00000000, 1'b1, 1'b1);
      stop_send();
      @(negedge clk);
      check("lat_n1_valid", m_tvalid, 0);
      check("lat_n1_level", fifo_level, 1);
      @(negedge clk);
      check("lat_n2_valid", m_tvalid, 1);
      check("lat_n2_data", m_tdata, 32'h00000000);
      drain("single", 20);

      // Back-to-back beats: 12 contiguous words, level peaks at 2.
      repeat (2) @(negedge clk);
      first_v = -1;
      lvl_max = 0;
      base = words_seen;
      for (int i = 0; i < 3; i++) send(mk(32'h00000100 + 32'(i) * 32'h10), 1'b1, 1'b1);
      stop_send();
      drain("b2b", 40);
      check("b2b_words", words_seen - base, 12);
      check("b2b_span", last_v - first_v + 1, 12);
      check("b2b_level_peak", lvl_max, 2);

      // Backpressure held at lane 2 for 10 cycles.
      send(mk(32'h00001000), 1'b1, 1'b1);
      stop_send();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      m_tready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold_data", m_tdata, 32'h00001002);
         check("bp_hold_valid", m_tvalid, 1);
      end
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      drain("bp", 20);

      // Overflow: 10 beats into a stalled 8-deep FIFO, 9 retained.
      m_tready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         send(mk(32'h00002000 + 32'(i) * 32'h10), 1'b1, (i < 9));
         if (i == 9) begin
            @(negedge clk);
            check("ovf_before", overflow, 0);
         end
      end
      stop_send();
      @(negedge clk);
      check("ovf_set", overflow, 1);
      check("ovf_level", fifo_level, 8);
      check("ovf_head", m_tdata, 32'h00002000);
      base = words_seen;
      @(posedge clk);
      #1;
      m_tready = 1'b1;
      drain("ovf", 100);
      check("ovf_words", words_seen - base, 36);
      check("ovf_sticky", overflow, 1);
      @(posedge clk);
      #1;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
      check("ovf_cleared", overflow, 0);
      check("clear_level", fifo_level, 0);

      // Framing: frame_len=3, last on words 12 and 24.
      frame_len = 8'd3;
      for (int i = 0; i < 6; i++) send(mk(32'h00003000 + 32'(i) * 32'h10), (i == 2 || i == 5), 1'b1);
      stop_send();
      drain("frame", 60);

      // Mid-frame clear after 5 words with frame_len=2.
      frame_len = 8'd2;
      base = words_seen;
      send(mk(32'h00004000), 1'b0, 1'b1);
      send(mk(32'h00004010), 1'b1, 1'b1);
      stop_send();
      n = 0;
      while (words_seen < base + 5 && n < 50) begin
         @(posedge clk);
         n++;
      end
      check("mid_reach5", words_seen - base, 5);
      #1;
      m_tready = 1'b0;
      clear = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("mid_clear_valid", m_tvalid, 0);
      check("mid_clear_level", fifo_level, 0);
      m_tready = 1'b1;
      send(mk(32'h00005000), 1'b0, 1'b1);
      send(mk(32'h00005010), 1'b1, 1'b1);
      stop_send();
      drain("mid_after", 40);

      check("final_queue", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
